// File: rtl/multicycle_core_if.sv
// Instruction and data memory buses of the multicycle core.
// The core drives requests through the master modport; memories answer through slave.
interface multicycle_core_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Small multicycle RISC-V subset core: ADD/SUB/AND/OR/ADDI, word load/store, BEQ.
// Unsupported instructions park the core in HALT until reset.
module multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_core_if.master bus,
  output logic            retired,
  output logic            halted,
  output logic [XLEN-1:0] pc_out
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic            retired_q, retired_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            rf_we_d;
  logic [XLEN-1:0] rf_wdata_d;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, pc_plus4;
  logic is_r, is_addi, is_load, is_store, is_beq;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rd_idx  = ir_q[7 +: RW];
  assign rs1_idx = ir_q[15 +: RW];
  assign rs2_idx = ir_q[20 +: RW];
  assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign pc_plus4 = pc_q + XLEN'(4);

  // SUB is the only R-type using funct7[5]; every other funct7 pattern is illegal.
  assign is_r     = (opcode == 7'b0110011) &&
                    (((funct7 == 7'h00) && (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110)) ||
                     ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we_d) begin
      regs_q[rd_idx] <= rf_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    retired_d  = 1'b0;
    rf_we_d    = 1'b0;
    rf_wdata_d = is_load ? mdr_q : alu_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = regs_q[rs1_idx];
        b_d     = regs_q[rs2_idx];
        imm_d   = is_store ? imm_s : (is_beq ? imm_b : imm_i);
        state_d = EXEC;
      end
      EXEC: begin
        if (is_beq) begin
          pc_d      = (a_q == b_q) ? pc_q + imm_q : pc_plus4;
          retired_d = 1'b1;
          state_d   = FETCH;
        end else if (is_load || is_store || is_addi) begin
          alu_d   = a_q + imm_q;
          state_d = is_addi ? WB : MEM;
        end else if (is_r) begin
          unique case (funct3)
            3'b111:  alu_d = a_q & b_q;
            3'b110:  alu_d = a_q | b_q;
            default: alu_d = funct7[5] ? a_q - b_q : a_q + b_q;
          endcase
          state_d = WB;
        end else begin
          state_d = HALT;
        end
      end
      MEM: begin
        if (bus.dmem_ready) begin
          if (is_store) begin
            pc_d      = pc_plus4;
            retired_d = 1'b1;
            state_d   = FETCH;
          end else begin
            mdr_d   = bus.dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we_d   = (rd_idx != '0);
        pc_d      = pc_plus4;
        retired_d = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  // Gating with reset keeps a fetch from being presented while reset is held.
  assign bus.imem_req   = (state_q == FETCH) && reset;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == MEM);
  assign bus.dmem_we    = (state_q == MEM) && is_store;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b_q;
  assign retired        = retired_q;
  assign halted         = (state_q == HALT);
  assign pc_out         = pc_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs, halt/reset behaviour, random programs
// against an instruction-level model, plus a 64-bit / 16-register instance.
module tb_multicycle_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        retired, halted;
  logic [31:0] pc_out;
  multicycle_core_if #(.XLEN(32)) bus();
  multicycle_core dut (
    .clk(clk), .reset(reset), .bus(bus),
    .retired(retired), .halted(halted), .pc_out(pc_out)
  );

  logic        reset64 = 1'b0;
  logic        ret64, halt64;
  logic [63:0] pc64;
  multicycle_core_if #(.XLEN(64)) bus64();
  multicycle_core #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .reset(reset64), .bus(bus64),
    .retired(ret64), .halted(halt64), .pc_out(pc64)
  );

  logic [31:0] rom64 [16];
  assign bus64.imem_ready = bus64.imem_req;
  assign bus64.imem_rdata = rom64[bus64.imem_addr[5:2]];
  assign bus64.dmem_ready = bus64.dmem_req;
  assign bus64.dmem_rdata = '0;

  // Memory responder for the 32-bit core with programmable wait states.
  logic [31:0] im [64];
  logic [31:0] dm [64];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  assign bus.imem_ready = bus.imem_req && (icnt == iwait);
  assign bus.imem_rdata = im[bus.imem_addr[7:2]];
  assign bus.dmem_ready = bus.dmem_req && (dcnt == dwait);
  assign bus.dmem_rdata = dm[bus.dmem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ready) icnt <= icnt + 1; else icnt <= 0;
    if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1; else dcnt <= 0;
    if (bus.dmem_ready && bus.dmem_we) dm[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
  end

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_e;
  typedef struct {
    kind_e k;
    int    rd;
    int    rs1;
    int    rs2;
    int    imm;
  } ins_t;

  ins_t        prog [64];
  logic [31:0] mx [32];
  logic [31:0] mdm [64];
  logic [31:0] mpc;
  logic [31:0] last_wdata;
  int n_assert = 0, n_fail = 0;

  function automatic ins_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
    ins_t r;
    r.k = k; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic logic [31:0] enc(ins_t i);
    logic [4:0]  rd, r1, r2;
    logic [11:0] i12;
    logic [12:0] b13;
    rd = i.rd[4:0]; r1 = i.rs1[4:0]; r2 = i.rs2[4:0];
    i12 = i.imm[11:0]; b13 = i.imm[12:0];
    case (i.k)
      K_ADD:  return {7'h00, r2, r1, 3'b000, rd, 7'b0110011};
      K_SUB:  return {7'h20, r2, r1, 3'b000, rd, 7'b0110011};
      K_AND:  return {7'h00, r2, r1, 3'b111, rd, 7'b0110011};
      K_OR:   return {7'h00, r2, r1, 3'b110, rd, 7'b0110011};
      K_ADDI: return {i12, r1, 3'b000, rd, 7'b0010011};
      K_LW:   return {i12, r1, 3'b010, rd, 7'b0000011};
      K_SW:   return {i12[11:5], r2, r1, 3'b010, i12[4:0], 7'b0100011};
      K_BEQ:  return {b13[12], b13[10:5], r2, r1, 3'b000, b13[4:1], b13[11], 7'b1100011};
      default: return 32'h0000_007F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) im[i] = enc(prog[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mx[i] = '0;
    mpc = '0;
  endtask

  // Predict one instruction from the program table, watch the core complete it, compare.
  task automatic exec_one();
    ins_t ci;
    logic [31:0] a, b, nxt, res, addr, oaddr, owdata;
    logic owe;
    int mem, lat, cyc, dcyc;
    bit got, overlap;
    ci = prog[mpc[7:2]];
    a = mx[ci.rs1]; b = mx[ci.rs2];
    nxt = mpc + 32'd4; res = '0; addr = '0; mem = 0; lat = 4;
    case (ci.k)
      K_ADD:  res = a + b;
      K_SUB:  res = a - b;
      K_AND:  res = a & b;
      K_OR:   res = a | b;
      K_ADDI: res = a + 32'(ci.imm);
      K_LW:   begin mem = 1; lat = 5; addr = a + 32'(ci.imm); res = mdm[addr[7:2]]; end
      K_SW:   begin mem = 2; addr = a + 32'(ci.imm); end
      K_BEQ:  begin lat = 3; if (a == b) nxt = mpc + 32'(ci.imm); end
      default: ;
    endcase
    lat += iwait + ((mem != 0) ? dwait : 0);
    got = 0; overlap = 0; cyc = 0; dcyc = 0;
    oaddr = '0; owdata = '0; owe = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.imem_req && bus.dmem_req) overlap = 1;
      if (bus.dmem_req) begin
        if (dcyc == 0) begin oaddr = bus.dmem_addr; owdata = bus.dmem_wdata; owe = bus.dmem_we; end
        dcyc++;
      end
      if (retired) got = 1;
    end
    chk("retire_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(lat));
    chk("pc_out", 64'(pc_out), 64'(nxt));
    chk("next_fetch_addr", 64'(bus.imem_addr), 64'(nxt));
    chk("req_overlap", 64'(overlap), 64'd0);
    chk("halted_low", 64'(halted), 64'd0);
    if (mem != 0) begin
      chk("dmem_addr", 64'(oaddr), 64'(addr));
      chk("dmem_we", 64'(owe), (mem == 2) ? 64'd1 : 64'd0);
      chk("dmem_req_cycles", 64'(dcyc), 64'(dwait + 1));
      if (mem == 2) chk("dmem_wdata", 64'(owdata), 64'(b));
    end else begin
      chk("no_dmem_req", 64'(dcyc), 64'd0);
    end
    if (ci.k == K_SW) begin
      mdm[addr[7:2]] = b;
      last_wdata = owdata;
    end else if (ci.k != K_BEQ && ci.rd != 0) begin
      mx[ci.rd] = res;
    end
    mpc = nxt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_req, any_ret, st_cnt;
    logic [63:0] st_addr [$];
    logic [63:0] st_data [$];

    for (int i = 0; i < 64; i++) begin
      prog[i] = mk(K_ILL, 0, 0, 0, 0);
      dm[i] = '0; mdm[i] = '0;
    end
    prog[0]  = mk(K_ADDI, 1, 0, 0, 5);
    prog[1]  = mk(K_ADDI, 2, 0, 0, 7);
    prog[2]  = mk(K_ADD,  3, 1, 2, 0);
    prog[3]  = mk(K_SW,   0, 0, 3, 16);
    prog[4]  = mk(K_LW,   4, 0, 0, 16);
    prog[5]  = mk(K_SW,   0, 0, 4, 32);
    prog[6]  = mk(K_BEQ,  0, 1, 2, -8);
    prog[7]  = mk(K_ADDI, 0, 0, 0, 9);
    prog[8]  = mk(K_ADDI, 5, 0, 0, -1);
    prog[9]  = mk(K_ADDI, 5, 5, 0, 1);
    prog[10] = mk(K_SW,   0, 0, 5, 36);
    prog[11] = mk(K_SW,   0, 0, 0, 40);
    prog[12] = mk(K_ADDI, 2, 0, 0, 5);
    prog[13] = mk(K_BEQ,  0, 0, 0, -28);
    load_prog();

    rom64[0] = enc(mk(K_ADDI, 1, 0, 0, -2));
    rom64[1] = enc(mk(K_SW,   0, 0, 1, 8));
    rom64[2] = enc(mk(K_ADDI, 17, 1, 0, 3));
    rom64[3] = enc(mk(K_SW,   0, 0, 1, 16));
    rom64[4] = enc(mk(K_ADDI, 2, 17, 0, 0));
    rom64[5] = enc(mk(K_SW,   0, 0, 2, 24));
    for (int i = 6; i < 16; i++) rom64[i] = 32'h0000_007F;

    // Reset state.
    iwait = 0; dwait = 3;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", 64'(pc_out), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
    model_reset();
    reset = 1'b1;
    #1 chk("first_fetch_addr", 64'(bus.imem_addr), 64'd0);

    // Directed program.
    for (int s = 1; s <= 17; s++) begin
      exec_one();
      $display("directed step %0d pc_out=0x%0h", s, pc_out);
      if (s == 3)  chk("pc_after_add", 64'(pc_out), 64'd12);
      if (s == 4)  chk("sw_x3_data", 64'(last_wdata), 64'd12);
      if (s == 6)  chk("lw_x4_data", 64'(last_wdata), 64'd12);
      if (s == 7)  chk("beq_not_taken", 64'(pc_out), 64'd28);
      if (s == 11) chk("x5_wrap", 64'(last_wdata), 64'd0);
      if (s == 12) chk("x0_zero", 64'(last_wdata), 64'd0);
      if (s == 15) chk("beq_taken", 64'(pc_out), 64'd16);
    end

    // Reset during a pending fetch, then an illegal instruction at PC_RESET.
    im[0] = 32'h0000_007F;
    iwait = 5;
    repeat (2) @(negedge clk);
    chk("fetch_pending", 64'(bus.imem_req), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abandon_req", 64'(bus.imem_req), 64'd0);
    chk("abandon_pc", 64'(pc_out), 64'd0);
    iwait = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_not_yet", 64'(halted), 64'd0);
    @(negedge clk);
    chk("halted", 64'(halted), 64'd1);
    any_req = 0; any_ret = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req) any_req++;
      if (retired) any_ret++;
    end
    $display("halt phase: requests=%0d retires=%0d", any_req, any_ret);
    chk("halt_no_req", 64'(any_req), 64'd0);
    chk("halt_no_retire", 64'(any_ret), 64'd0);
    chk("halt_sticky", 64'(halted), 64'd1);

    // One reset edge, then a random program.
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: prog[i] = mk(K_ADD, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        1: prog[i] = mk(K_SUB, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        2: prog[i] = mk(K_AND, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        3: prog[i] = mk(K_OR,  $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        6: prog[i] = mk(K_LW,  $urandom_range(0, 7), 0, 0, 4 * $urandom_range(0, 63));
        7: prog[i] = mk(K_SW,  0, 0, $urandom_range(0, 7), 4 * $urandom_range(0, 63));
        8: prog[i] = mk(K_BEQ, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                        4 * $urandom_range(0, 63) - 4 * i);
        default: prog[i] = mk(K_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), 0,
                              $urandom_range(0, 4095) - 2048);
      endcase
      dm[i] = $urandom; mdm[i] = dm[i];
    end
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("restart_req", 64'(bus.imem_req), 64'd1);
    chk("restart_addr", 64'(bus.imem_addr), 64'd0);
    chk("restart_halted", 64'(halted), 64'd0);
    model_reset();
    for (int s = 0; s < 200; s++) begin
      exec_one();
      $display("random step %0d pc_out=0x%0h iwait=%0d dwait=%0d", s, pc_out, iwait, dwait);
      iwait = $urandom_range(0, 2);
      dwait = $urandom_range(0, 3);
    end

    // 64-bit, 16-register instance.
    reset64 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus64.dmem_req && bus64.dmem_we) begin
        st_addr.push_back(bus64.dmem_addr);
        st_data.push_back(bus64.dmem_wdata);
        $display("x64 store addr=0x%0h data=0x%0h", bus64.dmem_addr, bus64.dmem_wdata);
      end
    end
    st_cnt = st_addr.size();
    chk("x64_store_count", 64'(st_cnt), 64'd3);
    if (st_cnt == 3) begin
      chk("x64_addr0", st_addr[0], 64'd8);
      chk("x64_neg2", st_data[0], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("x64_addr1", st_addr[1], 64'd16);
      chk("x64_alias_rd", st_data[1], 64'd1);
      chk("x64_alias_rs", st_data[2], 64'd1);
    end
    chk("x64_halted", 64'(halt64), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath, register and address width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32: architectural register count (16 or 32); register index uses the low log2(NREGS) bits of each field.
REQ-003 SHALL have parameter PC_RESET, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port imem_req  out  1: instruction fetch request.
REQ-007 SHALL have port imem_addr  out  XLEN: fetch byte address; equals PC.
REQ-008 SHALL have port imem_rdata  in  32: instruction word.
REQ-009 SHALL have port imem_ready  in  1: fetch complete; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port dmem_req  out  1: data access request.
REQ-011 SHALL have port dmem_we  out  1: 1 = store, 0 = load.
REQ-012 SHALL have port dmem_addr  out  XLEN: data byte address.
REQ-013 SHALL have port dmem_wdata  out  XLEN: store data.
REQ-014 SHALL have port dmem_rdata  in  XLEN: load data, valid with dmem_ready.
REQ-015 SHALL have port dmem_ready  in  1: data access complete.
REQ-016 SHALL have port retired  out  1: one-cycle pulse when an instruction completes.
REQ-017 SHALL have port halted  out  1: core is stopped.
REQ-018 SHALL have port pc_out  out  XLEN: current PC.

Function
REQ-019 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-020 In FETCH, SHALL hold imem_req=1 with imem_addr=PC until imem_ready=1, then latch imem_rdata into IR and go to DECODE; any number of wait cycles is legal.
REQ-021 In DECODE, SHALL latch A=x[rs1] and B=x[rs2], generate the sign-extended I/S/B immediate, and go to EXEC.
REQ-022 SHALL support ADD, SUB, AND, OR (opcode 0110011, selected by funct3 and funct7[5]), ADDI (0010011, funct3 000), load (0000011) and store (0100011) of one XLEN-bit word, and BEQ (1100011, funct3 000).
REQ-023 Any other opcode/funct combination SHALL enter HALT without modifying registers or memory; halted=1 from the next cycle.
REQ-024 In EXEC: R/ADDI latch ALUOut and go to WB; load/store latch ALUOut=A+imm and go to MEM; BEQ sets PC=PC+immB if A==B, else PC+4, pulses retired, and goes to FETCH.
REQ-025 In MEM, SHALL hold dmem_req=1, dmem_addr=ALUOut, dmem_we=store and dmem_wdata=B until dmem_ready=1.
REQ-026 On dmem_ready in MEM: a load latches MDR and goes to WB; a store sets PC+=4, pulses retired, and goes to FETCH.
REQ-027 In WB, SHALL write ALUOut or MDR to x[rd] unless rd==0, set PC+=4, pulse retired, and go to FETCH.
REQ-028 x0 SHALL read as 0 at all times.
REQ-029 All arithmetic and PC updates SHALL wrap modulo 2^XLEN; no overflow detection.
REQ-030 With zero-wait memories, latency SHALL be: BEQ 3 cycles, R/ADDI/store 4, load 5 (FETCH entry to return to FETCH).
REQ-031 dmem_req and imem_req SHALL never be asserted in the same cycle.
REQ-032 Outside FETCH, imem_req SHALL be 0; outside MEM, dmem_req and dmem_we SHALL be 0.
REQ-033 Address alignment SHALL NOT be checked; the low address bits pass through unchanged.
REQ-034 HALT SHALL be left only by reset.

Reset
REQ-035 While reset=0 at a clock edge: state=FETCH, PC=PC_RESET, IR=0, all registers=0, retired=0, halted=0, imem_req and dmem_req deasserted from the next cycle.
REQ-036 Reset asserted during a pending fetch or MEM access SHALL abandon the access with no register or PC side effect; the first request after reset uses PC_RESET.

Verification
REQ-037 Zero-wait memories, program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12, three retired pulses within 12 cycles, pc_out=12.
REQ-038 sw x3,16(x0) then lw x4,16(x0) with dmem_ready delayed 3 cycles each -> dmem_addr=16, dmem_wdata=12 on the store, x4=12, dmem_req held for 4 cycles per access.
REQ-039 x1=x2=5, beq x1,x2,-8 at PC=24 -> next fetch address 16; with x2=6 -> next fetch address 28; 3 cycles each.
REQ-040 addi x0,x0,9 -> x0 reads 0; XLEN=32: addi x5,x0,-1 then addi x5,x5,1 -> x5=0 (wrap).
REQ-041 Opcode 1111111 -> halted=1, no retired pulse, no further imem_req; reset=0 for one edge -> fetch resumes at PC_RESET.
REQ-042 XLEN=64, NREGS=16: addi x1,x0,-2 -> x1=0xFFFFFFFFFFFFFFFE; rd field 17 aliases to x1.
